// File: rtl/satalnk_txprim.sv
// TX primitive sequencer: inserts periodic ALIGN bursts, replaces repeated primitives with CONT
// plus junk, and fills data underflow with HOLD. Define SATALNK_JUNK_SCRAMBLE_EN to enable LFSR junk.
module satalnk_txprim #(
    parameter int          ALIGN_INTERVAL = 256,
    parameter int          ALIGN_BURST    = 2,
    parameter int          CONT_THRESHOLD = 2,
    parameter logic [32:0] P_ALIGN        = 33'h1_7B4A_4ABC,
    parameter logic [32:0] P_CONT         = 33'h1_9999_AA7C,
    parameter logic [32:0] P_HOLD         = 33'h1_D5D5_B57C,
    parameter logic [32:0] P_SYNC         = 33'h1_B5B5_957C
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_cfg_continue_en,
    input  logic        i_phy_ready,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [32:0] s_data,
    output logic        o_primitive,
    output logic [31:0] o_data,
    output logic        o_suppressing
);

    localparam int AW = $clog2(ALIGN_INTERVAL);
    localparam int BW = $clog2(ALIGN_BURST + 1);
    localparam int RW = $clog2(CONT_THRESHOLD + 2);

    localparam logic [AW-1:0] ALIGN_LAST = AW'(ALIGN_INTERVAL - 1);
    localparam logic [BW-1:0] BURST_LAST = BW'(ALIGN_BURST - 1);
    localparam logic [RW-1:0] REP_TRIG   = RW'(CONT_THRESHOLD + 1);

    localparam logic [1:0] S_ALIGN = 2'd0;
    localparam logic [1:0] S_PASS  = 2'd1;
    localparam logic [1:0] S_JUNK  = 2'd2;

    logic [1:0]    state, state_nx;
    logic [BW-1:0] burst_cnt, burst_nx;
    logic [AW-1:0] align_cnt, align_nx;
    logic [RW-1:0] rep_cnt, rep_nx, rep_inc, rep_cand;
    logic [32:0]   last, last_nx;
    logic [32:0]   eff;
    logic [32:0]   out_nx;
    logic          sup_nx;
    logic          boundary;
    logic [31:0]   junk;

    assign s_ready  = i_phy_ready && (state != S_ALIGN);
    // With no new input, a primitive stream keeps repeating; a data stream falls back to HOLD.
    assign eff      = s_valid ? s_data : (last[32] ? last : P_HOLD);
    assign boundary = (align_cnt == ALIGN_LAST);
    assign rep_inc  = (rep_cnt == REP_TRIG) ? rep_cnt : rep_cnt + 1'b1;

`ifdef SATALNK_JUNK_SCRAMBLE_EN
    logic [31:0] lfsr;
    logic        junk_adv;

    assign junk     = lfsr;
    assign junk_adv = (state == S_JUNK) && (eff == last) && i_cfg_continue_en && !boundary
                      || (state == S_JUNK) && (eff == last) && i_cfg_continue_en && boundary;

    // Galois form of x^32+x^22+x^2+x+1, stepped only when a junk dword goes out.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            lfsr <= 32'hFFFF_FFFF;
        end else if (i_phy_ready && junk_adv) begin
            lfsr <= {1'b0, lfsr[31:1]} ^ (lfsr[0] ? 32'h8020_0003 : 32'h0000_0000);
        end
    end
`else
    assign junk = 32'h0000_0000;
`endif

    always_comb begin
        state_nx = state;
        burst_nx = burst_cnt;
        align_nx = align_cnt;
        rep_nx   = rep_cnt;
        last_nx  = last;
        out_nx   = {o_primitive, o_data};
        sup_nx   = o_suppressing;
        rep_cand = (eff == last) ? rep_inc : RW'(1);

        case (state)
            S_ALIGN: begin
                out_nx = P_ALIGN;
                sup_nx = 1'b0;
                if (burst_cnt == BURST_LAST) begin
                    state_nx = S_PASS;
                    burst_nx = '0;
                    align_nx = '0;
                    rep_nx   = '0;
                end else begin
                    burst_nx = burst_cnt + 1'b1;
                end
            end
            S_PASS: begin
                out_nx = eff;
                sup_nx = 1'b0;
                if (!eff[32]) begin
                    rep_nx  = '0;
                    last_nx = eff;
                end else if (eff != P_ALIGN) begin
                    rep_nx  = rep_cand;
                    last_nx = eff;
                    // An imminent ALIGN burst wins; CONT is re-armed after the burst.
                    if (i_cfg_continue_en && (rep_cand == REP_TRIG) && !boundary) begin
                        out_nx   = P_CONT;
                        sup_nx   = 1'b1;
                        state_nx = S_JUNK;
                    end
                end
            end
            S_JUNK: begin
                if ((eff == last) && i_cfg_continue_en) begin
                    out_nx = {1'b0, junk};
                    sup_nx = 1'b1;
                end else begin
                    out_nx   = eff;
                    sup_nx   = 1'b0;
                    state_nx = S_PASS;
                    if (eff == P_ALIGN) begin
                        rep_nx = '0;
                    end else begin
                        rep_nx  = eff[32] ? RW'(1) : RW'(0);
                        last_nx = eff;
                    end
                end
            end
            default: begin
                state_nx = S_ALIGN;
                burst_nx = '0;
            end
        endcase

        if (state != S_ALIGN) begin
            if (boundary) begin
                state_nx = S_ALIGN;
                burst_nx = '0;
            end else begin
                align_nx = align_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state         <= S_ALIGN;
            burst_cnt     <= '0;
            align_cnt     <= '0;
            rep_cnt       <= '0;
            last          <= P_SYNC;
            o_primitive   <= 1'b1;
            o_data        <= P_ALIGN[31:0];
            o_suppressing <= 1'b0;
        end else if (i_phy_ready) begin
            state         <= state_nx;
            burst_cnt     <= burst_nx;
            align_cnt     <= align_nx;
            rep_cnt       <= rep_nx;
            last          <= last_nx;
            o_primitive   <= out_nx[32];
            o_data        <= out_nx[31:0];
            o_suppressing <= sup_nx;
        end
    end

endmodule

// File: tb/tb_satalnk_txprim.sv
// Scoreboard bench for satalnk_txprim with ALIGN_INTERVAL=8: directed vectors push hand-computed
// expectations, a monitor pops one per clock and compares s_ready and the registered outputs.
module tb_satalnk_txprim;

    localparam int ALIGN_INTERVAL = 8;

    localparam logic [32:0] P_ALIGN = 33'h1_7B4A_4ABC;
    localparam logic [32:0] P_CONT  = 33'h1_9999_AA7C;
    localparam logic [32:0] P_HOLD  = 33'h1_D5D5_B57C;
    localparam logic [32:0] X_RDY   = 33'h1_B5B5_957C;
    localparam logic [32:0] R_OK    = 33'h1_3535_B57C;

`ifdef SATALNK_JUNK_SCRAMBLE_EN
    localparam logic [32:0] J0 = {1'b0, 32'hFFFF_FFFF};
    localparam logic [32:0] J1 = {1'b0, 32'hFFDF_FFFC};
    localparam logic [32:0] J2 = {1'b0, 32'h7FEF_FFFE};
    localparam logic [32:0] J3 = {1'b0, 32'h3FF7_FFFF};
    localparam logic [32:0] J4 = {1'b0, 32'h9FDB_FFFC};
    localparam logic [32:0] J5 = {1'b0, 32'h4FED_FFFE};
    localparam logic [32:0] J6 = {1'b0, 32'h27F6_FFFF};
    localparam logic [32:0] J7 = {1'b0, 32'h93DB_7FFC};
`else
    localparam logic [32:0] J0 = 33'h0;
    localparam logic [32:0] J1 = 33'h0;
    localparam logic [32:0] J2 = 33'h0;
    localparam logic [32:0] J3 = 33'h0;
    localparam logic [32:0] J4 = 33'h0;
    localparam logic [32:0] J5 = 33'h0;
    localparam logic [32:0] J6 = 33'h0;
    localparam logic [32:0] J7 = 33'h0;
`endif

    typedef struct packed {
        logic [15:0] tag;
        logic        rdy;
        logic [32:0] out;
        logic        sup;
    } exp_t;

    logic        i_clk;
    logic        i_reset_n;
    logic        i_cfg_continue_en;
    logic        i_phy_ready;
    logic        s_valid;
    logic        s_ready;
    logic [32:0] s_data;
    logic        o_primitive;
    logic [31:0] o_data;
    logic        o_suppressing;

    exp_t exp_q[$];
    exp_t mon_item;
    logic mon_rdy;
    int   tests_run;
    int   tests_failed;
    int   vec_no;

    satalnk_txprim #(
        .ALIGN_INTERVAL(ALIGN_INTERVAL)
    ) dut (
        .i_clk            (i_clk),
        .i_reset_n        (i_reset_n),
        .i_cfg_continue_en(i_cfg_continue_en),
        .i_phy_ready      (i_phy_ready),
        .s_valid          (s_valid),
        .s_ready          (s_ready),
        .s_data           (s_data),
        .o_primitive      (o_primitive),
        .o_data           (o_data),
        .o_suppressing    (o_suppressing)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic checkOutput(input int tag, input string what, input logic [31:0] got,
                               input logic [31:0] want);
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("[TB] FAIL %s (vec %0d): got %h, expected %h", what, tag, got, want);
        end
    endtask

    // Drives one cycle of inputs at the negedge and records what the next edge must produce.
    task automatic applyStimulus(input logic rdy_in, input logic vld, input logic [32:0] din,
                                 input logic exp_rdy, input logic [32:0] exp_out,
                                 input logic exp_sup);
        exp_t e;
        vec_no++;
        i_phy_ready = rdy_in;
        s_valid     = vld;
        s_data      = din;
        e.tag = 16'(vec_no);
        e.rdy = exp_rdy;
        e.out = exp_out;
        e.sup = exp_sup;
        exp_q.push_back(e);
        @(negedge i_clk);
    endtask

    task automatic checkResetState(input int tag);
        checkOutput(tag, "rst o_primitive", 32'(o_primitive), 32'd1);
        checkOutput(tag, "rst o_data", o_data, P_ALIGN[31:0]);
        checkOutput(tag, "rst o_suppressing", 32'(o_suppressing), 32'd0);
        checkOutput(tag, "rst s_ready", 32'(s_ready), 32'd0);
    endtask

    always @(posedge i_clk) begin
        if (exp_q.size() != 0) begin
            mon_item = exp_q.pop_front();
            mon_rdy  = s_ready;
            #1;
            checkOutput(int'(mon_item.tag), "s_ready", 32'(mon_rdy), 32'(mon_item.rdy));
            checkOutput(int'(mon_item.tag), "o_primitive", 32'(o_primitive), 32'(mon_item.out[32]));
            checkOutput(int'(mon_item.tag), "o_data", o_data, mon_item.out[31:0]);
            checkOutput(int'(mon_item.tag), "o_suppressing", 32'(o_suppressing), 32'(mon_item.sup));
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        tests_run         = 0;
        tests_failed      = 0;
        vec_no            = 0;
        i_reset_n         = 1'b1;
        i_cfg_continue_en = 1'b1;
        i_phy_ready       = 1'b1;
        s_valid           = 1'b0;
        s_data            = 33'h0;
        #3 i_reset_n = 1'b0;
        #1 checkResetState(0);
        repeat (2) @(negedge i_clk);
        i_reset_n = 1'b1;

        // Window 1: startup burst, first data, X_RDY suppression, R_OK on the interval boundary.
        applyStimulus(1, 0, 33'h0, 0, P_ALIGN, 0);
        applyStimulus(1, 0, 33'h0, 0, P_ALIGN, 0);
        applyStimulus(1, 1, {1'b0, 32'h1234_5678}, 1, {1'b0, 32'h1234_5678}, 0);
        applyStimulus(1, 1, X_RDY, 1, X_RDY, 0);
        applyStimulus(1, 1, X_RDY, 1, X_RDY, 0);
        applyStimulus(1, 1, X_RDY, 1, P_CONT, 1);
        applyStimulus(1, 1, X_RDY, 1, J0, 1);
        applyStimulus(1, 1, X_RDY, 1, J1, 1);
        applyStimulus(1, 1, X_RDY, 1, J2, 1);
        applyStimulus(1, 1, R_OK, 1, R_OK, 0);
        applyStimulus(1, 1, {1'b0, 32'hAAAA_5555}, 0, P_ALIGN, 0);
        applyStimulus(1, 1, {1'b0, 32'hAAAA_5555}, 0, P_ALIGN, 0);

        // Window 2: underflow to HOLD, CONT, junk, a 5-cycle PHY stall, junk up to the boundary.
        applyStimulus(1, 1, {1'b0, 32'hAAAA_5555}, 1, {1'b0, 32'hAAAA_5555}, 0);
        applyStimulus(1, 0, 33'h0, 1, P_HOLD, 0);
        applyStimulus(1, 0, 33'h0, 1, P_HOLD, 0);
        applyStimulus(1, 0, 33'h0, 1, P_CONT, 1);
        applyStimulus(1, 0, 33'h0, 1, J3, 1);
        applyStimulus(1, 0, 33'h0, 1, J4, 1);
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 33'h0, 0, J4, 1);
        applyStimulus(1, 0, 33'h0, 1, J5, 1);
        applyStimulus(1, 0, 33'h0, 1, J6, 1);
        applyStimulus(1, 0, 33'h0, 0, P_ALIGN, 0);
        applyStimulus(1, 0, 33'h0, 0, P_ALIGN, 0);

        // Window 3: the burst cleared the repeat count, so HOLD goes out twice before CONT again.
        applyStimulus(1, 0, 33'h0, 1, P_HOLD, 0);
        applyStimulus(1, 0, 33'h0, 1, P_HOLD, 0);
        applyStimulus(1, 0, 33'h0, 1, P_CONT, 1);
        applyStimulus(1, 0, 33'h0, 1, J7, 1);

        #2 i_reset_n = 1'b0;
        #1 checkResetState(vec_no);
        repeat (2) @(negedge i_clk);
        i_reset_n = 1'b1;

        // After reset: junk restarts from the seed, then continuous data across two ALIGN bursts.
        applyStimulus(1, 1, X_RDY, 0, P_ALIGN, 0);
        applyStimulus(1, 1, X_RDY, 0, P_ALIGN, 0);
        applyStimulus(1, 1, X_RDY, 1, X_RDY, 0);
        applyStimulus(1, 1, X_RDY, 1, X_RDY, 0);
        applyStimulus(1, 1, X_RDY, 1, P_CONT, 1);
        applyStimulus(1, 1, X_RDY, 1, J0, 1);
        for (int d = 0; d < 4; d++)
            applyStimulus(1, 1, {1'b0, 32'(d)}, 1, {1'b0, 32'(d)}, 0);
        applyStimulus(1, 1, {1'b0, 32'd4}, 0, P_ALIGN, 0);
        applyStimulus(1, 1, {1'b0, 32'd4}, 0, P_ALIGN, 0);
        for (int d = 4; d < 12; d++)
            applyStimulus(1, 1, {1'b0, 32'(d)}, 1, {1'b0, 32'(d)}, 0);
        applyStimulus(1, 1, {1'b0, 32'd12}, 0, P_ALIGN, 0);
        applyStimulus(1, 1, {1'b0, 32'd12}, 0, P_ALIGN, 0);
        applyStimulus(1, 1, {1'b0, 32'd12}, 1, {1'b0, 32'd12}, 0);

        // With continue disabled a repeated primitive is never replaced.
        i_cfg_continue_en = 1'b0;
        for (int i = 0; i < 4; i++) applyStimulus(1, 1, R_OK, 1, R_OK, 0);

        repeat (3) @(negedge i_clk);
        checkOutput(vec_no, "scoreboard drained", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
